// File: rtl/capture_controller_if.sv
// Command, transmitter and per-channel FIFO signals of capture_controller.
// The master modport is the controller's view; slave is its environment.
interface capture_controller_if #(
   parameter int DATA_SIZE = 12,
   parameter int CHANNELS  = 4
);
   localparam int CH_BITS = $clog2(CHANNELS);

   logic [DATA_SIZE-1:0]          rx_data_i;
   logic                          rx_ready_i;
   logic [DATA_SIZE-1:0]          tx_data_o;
   logic [CH_BITS-1:0]            tx_chan_o;
   logic                          tx_write_en_o;
   logic                          tx_busy_i;
   logic [CHANNELS*DATA_SIZE-1:0] fifo_data_i;
   logic [CHANNELS-1:0]           fifo_empty_i;
   logic [CHANNELS-1:0]           fifo_read_en_o;
   logic                          busy_o;

   modport master (
      input  rx_data_i, rx_ready_i, tx_busy_i, fifo_data_i, fifo_empty_i,
      output tx_data_o, tx_chan_o, tx_write_en_o, fifo_read_en_o, busy_o
   );

   modport slave (
      output rx_data_i, rx_ready_i, tx_busy_i, fifo_data_i, fifo_empty_i,
      input  tx_data_o, tx_chan_o, tx_write_en_o, fifo_read_en_o, busy_o
   );
endinterface

// File: rtl/capture_controller.sv
// Multi-channel capture controller: decodes UART commands and streams samples
// from enabled FIFO channels, round-robin and channel-tagged, to the transmitter.
module capture_controller #(
   parameter int DATA_SIZE = 12,
   parameter int CHANNELS  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   capture_controller_if.master bus
);
   localparam int CH_BITS  = $clog2(CHANNELS);
   localparam int ARG_BITS = DATA_SIZE - 4;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SELECT  = 3'd1,
      S_READ    = 3'd2,
      S_LATCH   = 3'd3,
      S_WAIT_TX = 3'd4
   } state_t;

   state_t                state_q,      state_d;
   logic [CHANNELS-1:0]   mask_q,       mask_d;
   logic [CH_BITS-1:0]    last_q,       last_d;
   logic [ARG_BITS-1:0]   burst_cnt_q,  burst_cnt_d;
   logic                  burst_mode_q, burst_mode_d;
   logic                  stop_pend_q,  stop_pend_d;
   logic [DATA_SIZE-1:0]  tx_data_q,    tx_data_d;
   logic [CH_BITS-1:0]    tx_chan_q,    tx_chan_d;
   logic                  tx_we_q,      tx_we_d;
   logic [CHANNELS-1:0]   rd_en_q,      rd_en_d;
   logic                  busy_q;

   logic [3:0]            opcode_s;
   logic [ARG_BITS-1:0]   arg_s;
   logic                  cmd_send_s;
   logic                  cmd_stop_s;
   logic                  cmd_burst_s;
   logic                  cmd_chan_s;
   logic                  grant_s;
   logic [CH_BITS-1:0]    grant_ch_s;
   logic [CH_BITS-1:0]    scan_ch_s;
   logic [DATA_SIZE-1:0]  fifo_sel_s;

   function automatic logic [CH_BITS-1:0] next_chan(input logic [CH_BITS-1:0] ch);
      if (ch == CH_BITS'(CHANNELS - 1)) begin
         next_chan = '0;
      end else begin
         next_chan = ch + CH_BITS'(1);
      end
   endfunction

   function automatic logic [CHANNELS-1:0] onehot(input logic [CH_BITS-1:0] ch);
      onehot     = '0;
      onehot[ch] = 1'b1;
   endfunction

   assign opcode_s    = bus.rx_data_i[3:0];
   assign arg_s       = bus.rx_data_i[DATA_SIZE-1:4];
   assign cmd_send_s  = bus.rx_ready_i && (opcode_s == 4'h1);
   assign cmd_stop_s  = bus.rx_ready_i && (opcode_s == 4'h2);
   assign cmd_burst_s = bus.rx_ready_i && (opcode_s == 4'h3);
   assign cmd_chan_s  = bus.rx_ready_i && (opcode_s == 4'h4);

   // Round-robin scan starting after the last served channel.
   always_comb begin
      grant_s    = 1'b0;
      grant_ch_s = '0;
      scan_ch_s  = last_q;
      for (int k = 0; k < CHANNELS; k++) begin
         scan_ch_s = next_chan(scan_ch_s);
         if (!grant_s && mask_q[scan_ch_s] && !bus.fifo_empty_i[scan_ch_s]) begin
            grant_s    = 1'b1;
            grant_ch_s = scan_ch_s;
         end else begin
            grant_s    = grant_s;
         end
      end
   end

   // Slice of the FIFO data bus belonging to the channel that was popped.
   always_comb begin
      fifo_sel_s = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (last_q == CH_BITS'(c)) begin
            fifo_sel_s = bus.fifo_data_i[c*DATA_SIZE +: DATA_SIZE];
         end else begin
            fifo_sel_s = fifo_sel_s;
         end
      end
   end

   // Next-state logic for the controller FSM and its registered outputs.
   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      last_d       = last_q;
      burst_cnt_d  = burst_cnt_q;
      burst_mode_d = burst_mode_q;
      stop_pend_d  = stop_pend_q;
      tx_data_d    = tx_data_q;
      tx_chan_d    = tx_chan_q;
      tx_we_d      = tx_we_q;
      rd_en_d      = rd_en_q;

      if (cmd_chan_s) begin
         mask_d = arg_s[CHANNELS-1:0];
      end else begin
         mask_d = mask_q;
      end

      case (state_q)
         S_IDLE: begin
            if (cmd_send_s) begin
               state_d      = S_SELECT;
               burst_mode_d = 1'b0;
            end else if (cmd_burst_s && (arg_s != '0)) begin
               state_d      = S_SELECT;
               burst_mode_d = 1'b1;
               burst_cnt_d  = arg_s;
            end else begin
               state_d      = S_IDLE;
            end
         end
         S_SELECT: begin
            if (stop_pend_q || cmd_stop_s) begin
               state_d = S_IDLE;
            end else if (grant_s) begin
               rd_en_d = onehot(grant_ch_s);
               last_d  = grant_ch_s;
               state_d = S_READ;
            end else begin
               state_d = S_SELECT;
            end
         end
         S_READ: begin
            rd_en_d = '0;
            state_d = S_LATCH;
            if (cmd_stop_s) begin
               stop_pend_d = 1'b1;
            end else begin
               stop_pend_d = stop_pend_q;
            end
         end
         S_LATCH: begin
            tx_data_d = fifo_sel_s;
            tx_chan_d = last_q;
            tx_we_d   = 1'b1;
            state_d   = S_WAIT_TX;
            if (burst_mode_q) begin
               burst_cnt_d = burst_cnt_q - ARG_BITS'(1);
            end else begin
               burst_cnt_d = burst_cnt_q;
            end
            if (cmd_stop_s) begin
               stop_pend_d = 1'b1;
            end else begin
               stop_pend_d = stop_pend_q;
            end
         end
         S_WAIT_TX: begin
            tx_we_d = 1'b0;
            if (cmd_stop_s) begin
               stop_pend_d = 1'b1;
            end else begin
               stop_pend_d = stop_pend_q;
            end
            // The write strobe is still high only in the first WAIT_TX cycle,
            // which is when tx_busy_i has not yet had a chance to rise.
            if (!tx_we_q && !bus.tx_busy_i) begin
               if (stop_pend_q || (burst_mode_q && (burst_cnt_q == '0))) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_SELECT;
               end
            end else begin
               state_d = S_WAIT_TX;
            end
         end
         default: begin
            state_d = S_IDLE;
            rd_en_d = '0;
            tx_we_d = 1'b0;
         end
      endcase

      if (state_d == S_IDLE) begin
         stop_pend_d = 1'b0;
      end else begin
         stop_pend_d = stop_pend_d;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         mask_q       <= CHANNELS'(1);
         last_q       <= CH_BITS'(CHANNELS - 1);
         burst_cnt_q  <= '0;
         burst_mode_q <= 1'b0;
         stop_pend_q  <= 1'b0;
         tx_data_q    <= '0;
         tx_chan_q    <= '0;
         tx_we_q      <= 1'b0;
         rd_en_q      <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         last_q       <= last_d;
         burst_cnt_q  <= burst_cnt_d;
         burst_mode_q <= burst_mode_d;
         stop_pend_q  <= stop_pend_d;
         tx_data_q    <= tx_data_d;
         tx_chan_q    <= tx_chan_d;
         tx_we_q      <= tx_we_d;
         rd_en_q      <= rd_en_d;
         busy_q       <= (state_d != S_IDLE);
      end
   end

   assign bus.tx_data_o      = tx_data_q;
   assign bus.tx_chan_o      = tx_chan_q;
   assign bus.tx_write_en_o  = tx_we_q;
   assign bus.fifo_read_en_o = rd_en_q;
   assign bus.busy_o         = busy_q;
endmodule

// File: tb/tb_capture_controller.sv
// Directed bench for capture_controller with FIFO and transmitter models.
module tb_capture_controller;
   localparam int DATA_SIZE = 12;
   localparam int CHANNELS  = 4;

   logic clk_i = 1'b0;
   logic rst_i;

   always #5 clk_i = ~clk_i;

   capture_controller_if #(.DATA_SIZE(DATA_SIZE), .CHANNELS(CHANNELS)) bus ();

   capture_controller #(.DATA_SIZE(DATA_SIZE), .CHANNELS(CHANNELS)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [DATA_SIZE-1:0] fifo_mem [CHANNELS][64];
   int                   fifo_wr  [CHANNELS] = '{default: 0};
   int                   fifo_rd  [CHANNELS] = '{default: 0};
   int                   pop_cnt  [CHANNELS] = '{default: 0};
   logic [CHANNELS-1:0]  tb_mask;
   int                   tx_hold   = 0;
   int                   busy_left = 0;
   logic                 prev_we   = 1'b0;
   logic [DATA_SIZE-1:0] stage_data = '0;
   int                   stage_ch   = 0;
   int                   stage_seq  = 0;
   int                   stage_done = 0;
   logic [DATA_SIZE-1:0] wr_data [$];
   int                   wr_chan [$];
   int                   wr_cyc  [$];
   int                   we_run  = 0;
   int                   we_long = 0;
   int                   viol    = 0;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_empty
      assign bus.fifo_empty_i[c] = (fifo_rd[c] >= fifo_wr[c]);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] wd(input int k);
      if (k < wr_data.size()) wd = 32'(wr_data[k]);
      else wd = 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] wc(input int k);
      if (k < wr_chan.size()) wc = 32'(wr_chan[k]);
      else wc = 32'hFFFF_FFFF;
   endfunction

   // Transmitter busy model and registered FIFO read data, updated just after each edge.
   always @(posedge clk_i) begin
      #1;
      if (rst_i) begin
         busy_left = 0;
         prev_we   = 1'b0;
      end else begin
         if (busy_left > 0) busy_left--;
         if (prev_we) busy_left = tx_hold;
         prev_we = bus.tx_write_en_o;
      end
      bus.tx_busy_i = (busy_left > 0);
      if (stage_done != stage_seq) begin
         bus.fifo_data_i[stage_ch*DATA_SIZE +: DATA_SIZE] = stage_data;
         stage_done = stage_seq;
      end
   end

   // Mid-cycle monitor: pop legality, FIFO pops and transmitted-word log.
   always @(negedge clk_i) begin
      cyc++;
      if (!rst_i) begin
         if (!$onehot0(bus.fifo_read_en_o)) viol++;
         for (int c = 0; c < CHANNELS; c++) begin
            if (bus.fifo_read_en_o[c]) begin
               pop_cnt[c]++;
               if ((fifo_rd[c] >= fifo_wr[c]) || !tb_mask[c]) begin
                  viol++;
               end else begin
                  stage_data = fifo_mem[c][fifo_rd[c] % 64];
                  stage_ch   = c;
                  stage_seq++;
                  fifo_rd[c]++;
               end
            end
         end
         if (bus.tx_write_en_o) begin
            wr_data.push_back(bus.tx_data_o);
            wr_chan.push_back(int'(bus.tx_chan_o));
            wr_cyc.push_back(cyc);
            we_run++;
            if (we_run > 1) we_long++;
         end else begin
            we_run = 0;
         end
      end else begin
         we_run = 0;
      end
   end

   task automatic push(input int c, input logic [DATA_SIZE-1:0] v);
      fifo_mem[c][fifo_wr[c] % 64] = v;
      fifo_wr[c]++;
   endtask

   task automatic cmd(input logic [DATA_SIZE-1:0] w);
      bus.rx_data_i  = w;
      bus.rx_ready_i = 1'b1;
      @(negedge clk_i);
      bus.rx_ready_i = 1'b0;
      bus.rx_data_i  = '0;
   endtask

   task automatic do_reset();
      rst_i          = 1'b1;
      bus.rx_ready_i = 1'b0;
      tb_mask        = 4'b0001;
      for (int c = 0; c < CHANNELS; c++) fifo_wr[c] = fifo_rd[c];
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic wait_wr(input int n, input int budget);
      int i = 0;
      while ((wr_data.size() < n) && (i < budget)) begin
         @(negedge clk_i);
         i++;
      end
   endtask

   task automatic wait_idle(input int budget);
      int i = 0;
      while (bus.busy_o && (i < budget)) begin
         @(negedge clk_i);
         i++;
      end
   endtask

   initial begin
      int base;
      int p0;
      int p1;
      int p2;
      int hits;
      int i;
      int ord [3];
      logic [DATA_SIZE-1:0] e1 [3];

      rst_i          = 1'b1;
      bus.rx_data_i  = '0;
      bus.rx_ready_i = 1'b0;
      tb_mask        = 4'b0001;
      e1[0] = 12'hA01; e1[1] = 12'hB02; e1[2] = 12'hC03;
      ord[0] = 0; ord[1] = 1; ord[2] = 3;
      repeat (3) @(negedge clk_i);
      check_eq("rst_tx_data", 32'(bus.tx_data_o), 32'h0);
      check_eq("rst_tx_chan", 32'(bus.tx_chan_o), 32'h0);
      check_eq("rst_tx_we",   32'(bus.tx_write_en_o), 32'h0);
      check_eq("rst_rd_en",   32'(bus.fifo_read_en_o), 32'h0);
      check_eq("rst_busy",    32'(bus.busy_o), 32'h0);
      rst_i = 1'b0;

      // Continuous SEND on channel 0 with a slow transmitter.
      push(0, e1[0]); push(0, e1[1]); push(0, e1[2]);
      tx_hold = 2;
      cmd(12'h001);
      check_eq("t1_busy_on", 32'(bus.busy_o), 32'h1);
      wait_wr(3, 200);
      for (int k = 0; k < 3; k++) begin
         check_eq("t1_data", wd(k), 32'(e1[k]));
         check_eq("t1_chan", wc(k), 32'h0);
      end
      repeat (10) @(negedge clk_i);
      check_eq("t1_nwr", 32'(wr_data.size()), 32'd3);
      check_eq("t1_pops", 32'(pop_cnt[0]), 32'd3);
      check_eq("t1_select_busy", 32'(bus.busy_o), 32'h1);
      cmd(12'h002);
      check_eq("t1_stop_idle", 32'(bus.busy_o), 32'h0);

      // Mask 0b1011: channels 0,1,3 in turn, channel 2 never touched.
      do_reset();
      base = wr_data.size();
      p2   = pop_cnt[2];
      tb_mask = 4'b1011;
      cmd(12'h0B4);
      for (int c = 0; c < CHANNELS; c++)
         for (int j = 0; j < 3; j++) push(c, 12'(c*256 + 16 + j));
      tx_hold = 0;
      cmd(12'h001);
      wait_wr(base + 9, 300);
      for (int k = 0; k < 9; k++) begin
         check_eq("t2_chan", wc(base + k), 32'(ord[k % 3]));
         check_eq("t2_data", wd(base + k), 32'(ord[k % 3]*256 + 16 + k/3));
      end
      if (wr_cyc.size() >= base + 2)
         check_eq("t2_period", 32'(wr_cyc[base+1] - wr_cyc[base]), 32'd5);
      else
         check_eq("t2_period_nwr", 32'(wr_cyc.size()), 32'(base + 2));
      cmd(12'h002);
      wait_idle(20);
      check_eq("t2_idle", 32'(bus.busy_o), 32'h0);
      check_eq("t2_ch2_pops", 32'(pop_cnt[2] - p2), 32'd0);

      // BURST of 5 over channels 0 and 1, ends without STOP.
      do_reset();
      base = wr_data.size();
      p0 = pop_cnt[0]; p1 = pop_cnt[1];
      tb_mask = 4'b0011;
      cmd(12'h034);
      for (int j = 0; j < 4; j++) begin
         push(0, 12'(12'h300 + j));
         push(1, 12'(12'h310 + j));
      end
      tx_hold = 1;
      cmd(12'h053);
      wait_wr(base + 5, 300);
      wait_idle(50);
      repeat (10) @(negedge clk_i);
      check_eq("t3_idle", 32'(bus.busy_o), 32'h0);
      check_eq("t3_nwr", 32'(wr_data.size() - base), 32'd5);
      for (int k = 0; k < 5; k++) begin
         check_eq("t3_chan", wc(base + k), 32'(k % 2));
         check_eq("t3_data", wd(base + k), 32'(12'h300 + 16*(k % 2) + k/2));
      end
      check_eq("t3_pops0", 32'(pop_cnt[0] - p0), 32'd3);
      check_eq("t3_pops1", 32'(pop_cnt[1] - p1), 32'd2);

      // STOP in the same cycle as the pop strobe: popped word still goes out.
      do_reset();
      base = wr_data.size();
      p0 = pop_cnt[0];
      for (int j = 0; j < 3; j++) push(0, 12'(12'h400 + j));
      tx_hold = 1;
      cmd(12'h001);
      i = 0;
      while ((bus.fifo_read_en_o == '0) && (i < 50)) begin
         @(negedge clk_i);
         i++;
      end
      check_eq("t4_pop_seen", 32'(bus.fifo_read_en_o != '0), 32'h1);
      cmd(12'h002);
      wait_idle(50);
      repeat (10) @(negedge clk_i);
      check_eq("t4_idle", 32'(bus.busy_o), 32'h0);
      check_eq("t4_nwr", 32'(wr_data.size() - base), 32'd1);
      check_eq("t4_data", wd(base), 32'h400);
      check_eq("t4_pops", 32'(pop_cnt[0] - p0), 32'd1);

      // Reset while waiting on the transmitter.
      do_reset();
      tb_mask = 4'b0110;
      cmd(12'h064);
      for (int j = 0; j < 2; j++) begin
         push(1, 12'(12'h510 + j));
         push(2, 12'(12'h520 + j));
      end
      tx_hold = 3;
      cmd(12'h001);
      i = 0;
      while (!bus.tx_write_en_o && (i < 50)) begin
         @(negedge clk_i);
         i++;
      end
      check_eq("t5_write_seen", 32'(bus.tx_write_en_o), 32'h1);
      rst_i = 1'b1;
      @(negedge clk_i);
      check_eq("t5_rst_tx_data", 32'(bus.tx_data_o), 32'h0);
      check_eq("t5_rst_tx_chan", 32'(bus.tx_chan_o), 32'h0);
      check_eq("t5_rst_tx_we",   32'(bus.tx_write_en_o), 32'h0);
      check_eq("t5_rst_rd_en",   32'(bus.fifo_read_en_o), 32'h0);
      check_eq("t5_rst_busy",    32'(bus.busy_o), 32'h0);
      rst_i   = 1'b0;
      tb_mask = 4'b0001;
      push(0, 12'h500);
      base = wr_data.size();
      cmd(12'h001);
      wait_wr(base + 1, 100);
      check_eq("t5_first_chan", wc(base), 32'h0);
      check_eq("t5_first_data", wd(base), 32'h500);
      cmd(12'h002);
      wait_idle(50);

      // BURST N=0 and an unknown opcode do nothing.
      do_reset();
      base = wr_data.size();
      p0   = pop_cnt[0];
      hits = 0;
      push(0, 12'h600);
      cmd(12'h003);
      for (int k = 0; k < 5; k++) begin
         if (bus.busy_o || bus.tx_write_en_o || (bus.fifo_read_en_o != '0)) hits++;
         @(negedge clk_i);
      end
      cmd(12'h017);
      for (int k = 0; k < 5; k++) begin
         if (bus.busy_o || bus.tx_write_en_o || (bus.fifo_read_en_o != '0)) hits++;
         @(negedge clk_i);
      end
      check_eq("t6_activity", 32'(hits), 32'd0);
      check_eq("t6_nwr", 32'(wr_data.size() - base), 32'd0);
      check_eq("t6_pops", 32'(pop_cnt[0] - p0), 32'd0);

      check_eq("pop_legality", 32'(viol), 32'd0);
      check_eq("we_one_cycle", 32'(we_long), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
